// File: rtl/stack_mem_sequencer_if.sv
// Command / data-memory bus of the stack sequencer.
//   master: upstream pipeline and data memory side (drives commands, operands, mem_rdata)
//   slave : the sequencer itself (drives strobes, selects, addresses and read-back results)
// mem_wdata carries the word picked by data_sel from the operands latched at acceptance.
interface stack_mem_sequencer_if #(
  parameter int unsigned AW = 12
) ();
  logic          cmd_valid;
  logic [2:0]    cmd;
  logic [15:0]   alu_out;
  logic [AW-1:0] ea;
  logic [31:0]   pc;
  logic [2:0]    ccr;
  logic          int_req;
  logic [15:0]   mem_rdata;

  logic          busy;
  logic          mem_rd;
  logic          mem_wr;
  logic [1:0]    data_sel;
  logic          addr_sel;
  logic [AW-1:0] stack_addr;
  logic [AW-1:0] ea_q;
  logic [15:0]   mem_wdata;
  logic          rd_valid;
  logic [15:0]   rd_data;
  logic          pc_valid;
  logic [31:0]   pc_out;
  logic          ccr_valid;
  logic [2:0]    ccr_out;

  modport master (
    output cmd_valid, cmd, alu_out, ea, pc, ccr, int_req, mem_rdata,
    input  busy, mem_rd, mem_wr, data_sel, addr_sel, stack_addr, ea_q, mem_wdata,
    input  rd_valid, rd_data, pc_valid, pc_out, ccr_valid, ccr_out
  );

  modport slave (
    input  cmd_valid, cmd, alu_out, ea, pc, ccr, int_req, mem_rdata,
    output busy, mem_rd, mem_wr, data_sel, addr_sel, stack_addr, ea_q, mem_wdata,
    output rd_valid, rd_data, pc_valid, pc_out, ccr_valid, ccr_out
  );
endinterface

// File: rtl/stack_mem_sequencer.sv
// Stack / data-memory sequencer. Accepts one memory-class command in IDLE, latches its
// operands, owns the stack pointer and turns each command into a sequence of 16-bit
// data-memory accesses. Popped words, return PCs and restored flags are presented with
// single-cycle valid pulses.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - stack_mem_sequencer_if.slave: command/operand inputs, memory strobes, selects,
//          addresses, write data and read-back results
module stack_mem_sequencer #(
  parameter int unsigned   AW       = 12,
  parameter logic [AW-1:0] SP_RESET = 12'hFFF
) (
  input logic                   clk,
  input logic                   rst,
  stack_mem_sequencer_if.slave  bus
);

  localparam logic [2:0] CmdPush = 3'd0;
  localparam logic [2:0] CmdPop  = 3'd1;
  localparam logic [2:0] CmdCall = 3'd2;
  localparam logic [2:0] CmdRet  = 3'd3;
  localparam logic [2:0] CmdInt  = 3'd4;
  localparam logic [2:0] CmdRti  = 3'd5;
  localparam logic [2:0] CmdLdd  = 3'd6;
  localparam logic [2:0] CmdStd  = 3'd7;

  localparam logic [1:0] SelAlu  = 2'b00;
  localparam logic [1:0] SelPcLo = 2'b01;
  localparam logic [1:0] SelPcHi = 2'b10;
  localparam logic [1:0] SelCcr  = 2'b11;

  typedef enum logic [4:0] {
    StIdle,
    StPu,
    StPo, StPd,
    StSt,
    StLd, StLdw,
    StC0, StC1,
    StI0, StI1, StI2,
    StR0, StR1, StR2,
    StT0, StT1, StT2, StT3
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] sp_q, sp_d;
  logic [AW-1:0] sp_inc, sp_dec;

  // Operands captured at acceptance.
  logic [15:0]   alu_q;
  logic [AW-1:0] ea_q;
  logic [31:0]   pc_q;
  logic [2:0]    ccr_in_q;

  // Read-back state.
  logic [15:0]   pcl_q, pcl_d;
  logic [2:0]    ccr_q, ccr_d;
  logic [15:0]   rd_hold_q;
  logic [31:0]   pc_hold_q;

  logic          accept;
  logic          mem_rd, mem_wr, addr_sel;
  logic [1:0]    data_sel;
  logic [AW-1:0] stack_addr;
  logic          rd_valid, pc_valid, ccr_valid;

  assign sp_inc = sp_q + AW'(1);
  assign sp_dec = sp_q - AW'(1);

  always_comb begin
    state_d    = state_q;
    sp_d       = sp_q;
    accept     = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    data_sel   = SelAlu;
    addr_sel   = 1'b0;
    stack_addr = sp_q;
    rd_valid   = 1'b0;
    pc_valid   = 1'b0;
    ccr_valid  = 1'b0;
    pcl_d      = pcl_q;
    ccr_d      = ccr_q;

    case (state_q)
      StIdle: begin
        // int_req wins over any command offered in the same cycle.
        if (bus.int_req) begin
          accept  = 1'b1;
          state_d = StI0;
        end else if (bus.cmd_valid) begin
          accept = 1'b1;
          case (bus.cmd)
            CmdPush: state_d = StPu;
            CmdPop:  state_d = StPo;
            CmdCall: state_d = StC0;
            CmdRet:  state_d = StR0;
            CmdInt:  state_d = StI0;
            CmdRti:  state_d = StT0;
            CmdLdd:  state_d = StLd;
            CmdStd:  state_d = StSt;
            default: state_d = StIdle;
          endcase
        end
      end

      // Pushes write at SP then decrement.
      StPu: begin
        mem_wr  = 1'b1;
        sp_d    = sp_dec;
        state_d = StIdle;
      end
      StC0: begin
        mem_wr   = 1'b1;
        data_sel = SelPcHi;
        sp_d     = sp_dec;
        state_d  = StC1;
      end
      StC1: begin
        mem_wr   = 1'b1;
        data_sel = SelPcLo;
        sp_d     = sp_dec;
        state_d  = StIdle;
      end
      StI0: begin
        mem_wr   = 1'b1;
        data_sel = SelPcHi;
        sp_d     = sp_dec;
        state_d  = StI1;
      end
      StI1: begin
        mem_wr   = 1'b1;
        data_sel = SelPcLo;
        sp_d     = sp_dec;
        state_d  = StI2;
      end
      StI2: begin
        mem_wr   = 1'b1;
        data_sel = SelCcr;
        sp_d     = sp_dec;
        state_d  = StIdle;
      end

      // Pops pre-increment and read at the new SP; data returns one cycle later.
      StPo: begin
        mem_rd     = 1'b1;
        stack_addr = sp_inc;
        sp_d       = sp_inc;
        state_d    = StPd;
      end
      StPd: begin
        rd_valid = 1'b1;
        state_d  = StIdle;
      end
      StR0: begin
        mem_rd     = 1'b1;
        stack_addr = sp_inc;
        sp_d       = sp_inc;
        state_d    = StR1;
      end
      StR1: begin
        mem_rd     = 1'b1;
        stack_addr = sp_inc;
        sp_d       = sp_inc;
        pcl_d      = bus.mem_rdata;
        state_d    = StR2;
      end
      StR2: begin
        pc_valid = 1'b1;
        state_d  = StIdle;
      end
      StT0: begin
        mem_rd     = 1'b1;
        stack_addr = sp_inc;
        sp_d       = sp_inc;
        state_d    = StT1;
      end
      StT1: begin
        mem_rd     = 1'b1;
        stack_addr = sp_inc;
        sp_d       = sp_inc;
        ccr_d      = bus.mem_rdata[2:0];
        state_d    = StT2;
      end
      StT2: begin
        mem_rd     = 1'b1;
        stack_addr = sp_inc;
        sp_d       = sp_inc;
        pcl_d      = bus.mem_rdata;
        state_d    = StT3;
      end
      StT3: begin
        pc_valid  = 1'b1;
        ccr_valid = 1'b1;
        state_d   = StIdle;
      end

      // Direct accesses at the latched effective address; SP untouched.
      StSt: begin
        mem_wr   = 1'b1;
        addr_sel = 1'b1;
        state_d  = StIdle;
      end
      StLd: begin
        mem_rd   = 1'b1;
        addr_sel = 1'b1;
        state_d  = StLdw;
      end
      StLdw: begin
        rd_valid = 1'b1;
        state_d  = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      sp_q      <= SP_RESET;
      alu_q     <= '0;
      ea_q      <= '0;
      pc_q      <= '0;
      ccr_in_q  <= '0;
      pcl_q     <= '0;
      ccr_q     <= '0;
      rd_hold_q <= '0;
      pc_hold_q <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      pcl_q   <= pcl_d;
      ccr_q   <= ccr_d;
      if (accept) begin
        alu_q    <= bus.alu_out;
        ea_q     <= bus.ea;
        pc_q     <= bus.pc;
        ccr_in_q <= bus.ccr;
      end
      if (rd_valid) rd_hold_q <= bus.mem_rdata;
      if (pc_valid) pc_hold_q <= {bus.mem_rdata, pcl_q};
    end
  end

  assign bus.busy       = (state_q != StIdle);
  assign bus.mem_rd     = mem_rd;
  assign bus.mem_wr     = mem_wr;
  assign bus.data_sel   = data_sel;
  assign bus.addr_sel   = addr_sel;
  assign bus.stack_addr = stack_addr;
  assign bus.ea_q       = ea_q;
  assign bus.rd_valid   = rd_valid;
  assign bus.pc_valid   = pc_valid;
  assign bus.ccr_valid  = ccr_valid;
  assign bus.ccr_out    = ccr_q;

  // Results track mem_rdata during their pulse and hold the last value afterwards.
  assign bus.rd_data = rd_valid ? bus.mem_rdata : rd_hold_q;
  assign bus.pc_out  = pc_valid ? {bus.mem_rdata, pcl_q} : pc_hold_q;

  always_comb begin
    case (data_sel)
      SelAlu:  bus.mem_wdata = alu_q;
      SelPcLo: bus.mem_wdata = pc_q[15:0];
      SelPcHi: bus.mem_wdata = pc_q[31:16];
      default: bus.mem_wdata = {13'b0, ccr_in_q};
    endcase
  end

endmodule

// File: tb/tb_stack_mem_sequencer.sv
module tb_stack_mem_sequencer;
  localparam int unsigned AW = 12;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stack_mem_sequencer_if #(.AW(AW)) bus ();

  stack_mem_sequencer #(.AW(AW), .SP_RESET(12'hFFF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Data memory: synchronous write, read data valid the cycle after mem_rd.
  logic [15:0] mem [4096];
  logic [11:0] phys;
  assign phys = bus.addr_sel ? bus.ea_q : bus.stack_addr;
  always @(posedge clk) begin
    if (bus.mem_wr) mem[phys] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= mem[phys];
  end

  typedef struct packed {
    logic        asel;
    logic [1:0]  sel;
    logic [11:0] addr;
    logic [15:0] data;
  } acc_t;

  acc_t        exp_wr[$];
  acc_t        exp_rd[$];
  logic [15:0] exp_rdv[$];
  logic [31:0] exp_pc[$];
  logic [2:0]  exp_ccr[$];
  logic [15:0] ref_mem [4096];
  logic [11:0] sp_m;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic m_wr(input logic asel, input logic [1:0] sel, input logic [11:0] a,
                      input logic [15:0] d);
    acc_t e;
    e = '{asel: asel, sel: sel, addr: a, data: d};
    exp_wr.push_back(e);
    ref_mem[a] = d;
  endtask

  task automatic m_rd(input logic asel, input logic [11:0] a, output logic [15:0] d);
    acc_t e;
    e = '{asel: asel, sel: 2'b00, addr: a, data: 16'h0};
    exp_rd.push_back(e);
    d = ref_mem[a];
  endtask

  task automatic push_m(input logic [1:0] sel, input logic [15:0] d);
    m_wr(1'b0, sel, sp_m, d);
    sp_m = sp_m - 12'd1;
  endtask

  task automatic pop_m(output logic [15:0] d);
    sp_m = sp_m + 12'd1;
    m_rd(1'b0, sp_m, d);
  endtask

  // Expected accesses, results and busy length for one command.
  task automatic apply_model(input logic [2:0] c, input logic [15:0] alu, input logic [11:0] e,
                             input logic [31:0] p, input logic [2:0] f, output int busy_n);
    logic [15:0] lo, hi, cc;
    case (c)
      3'd0: begin push_m(2'b00, alu); busy_n = 1; end
      3'd1: begin pop_m(lo); exp_rdv.push_back(lo); busy_n = 2; end
      3'd2: begin push_m(2'b10, p[31:16]); push_m(2'b01, p[15:0]); busy_n = 2; end
      3'd3: begin pop_m(lo); pop_m(hi); exp_pc.push_back({hi, lo}); busy_n = 3; end
      3'd4: begin
        push_m(2'b10, p[31:16]); push_m(2'b01, p[15:0]); push_m(2'b11, {13'b0, f});
        busy_n = 3;
      end
      3'd5: begin
        pop_m(cc); pop_m(lo); pop_m(hi);
        exp_ccr.push_back(cc[2:0]); exp_pc.push_back({hi, lo});
        busy_n = 4;
      end
      3'd6: begin m_rd(1'b1, e, lo); exp_rdv.push_back(lo); busy_n = 2; end
      default: begin m_wr(1'b1, 2'b00, e, alu); busy_n = 1; end
    endcase
  endtask

  task automatic issue(input logic [2:0] c, input logic irq, input logic [15:0] alu,
                       input logic [11:0] e, input logic [31:0] p, input logic [2:0] f);
    int exp_busy;
    int n;
    apply_model(irq ? 3'd4 : c, alu, e, p, f, exp_busy);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd       = c;
    bus.int_req   = irq;
    bus.alu_out   = alu;
    bus.ea        = e;
    bus.pc        = p;
    bus.ccr       = f;
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    bus.int_req   = 1'b0;
    n = 0;
    while (bus.busy && n < 16) begin
      n++;
      @(posedge clk);
      #1;
    end
    check("busy_cycles", 64'(n), 64'(exp_busy));
    check("sp", 64'(bus.stack_addr), 64'(sp_m));
  endtask

  // Monitor: every strobe and pulse pops the matching scoreboard entry.
  always @(negedge clk) begin
    acc_t a, e;
    if (bus.mem_wr) begin
      a = '{asel: bus.addr_sel, sel: bus.data_sel, addr: phys, data: bus.mem_wdata};
      if (exp_wr.size() == 0) check("wr_unexpected", 64'(a), 64'(0));
      else begin
        e = exp_wr.pop_front();
        check("wr_access", 64'(a), 64'(e));
      end
    end
    if (bus.mem_rd) begin
      a = '{asel: bus.addr_sel, sel: bus.data_sel, addr: phys, data: 16'h0};
      if (exp_rd.size() == 0) check("rd_unexpected", 64'(a), 64'(0));
      else begin
        e = exp_rd.pop_front();
        check("rd_access", 64'(a), 64'(e));
      end
    end
    if (bus.rd_valid) begin
      if (exp_rdv.size() == 0) check("rd_valid_unexpected", 64'(bus.rd_data), 64'(0));
      else check("rd_data", 64'(bus.rd_data), 64'(exp_rdv.pop_front()));
    end
    if (bus.pc_valid) begin
      if (exp_pc.size() == 0) check("pc_valid_unexpected", 64'(bus.pc_out), 64'(0));
      else check("pc_out", 64'(bus.pc_out), 64'(exp_pc.pop_front()));
    end
    if (bus.ccr_valid) begin
      check("ccr_with_pc", 64'(bus.pc_valid), 64'(1));
      if (exp_ccr.size() == 0) check("ccr_valid_unexpected", 64'(bus.ccr_out), 64'(0));
      else check("ccr_out", 64'(bus.ccr_out), 64'(exp_ccr.pop_front()));
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    sp_m = 12'hFFF;
  endtask

  initial begin
    int dummy;
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd       = 3'd0;
    bus.int_req   = 1'b0;
    bus.alu_out   = 16'h0;
    bus.ea        = 12'h0;
    bus.pc        = 32'h0;
    bus.ccr       = 3'b0;
    sp_m          = 12'hFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    check("rst_busy",       64'(bus.busy),       64'(0));
    check("rst_mem_rd",     64'(bus.mem_rd),     64'(0));
    check("rst_mem_wr",     64'(bus.mem_wr),     64'(0));
    check("rst_data_sel",   64'(bus.data_sel),   64'(0));
    check("rst_addr_sel",   64'(bus.addr_sel),   64'(0));
    check("rst_valids",     64'({bus.rd_valid, bus.pc_valid, bus.ccr_valid}), 64'(0));
    check("rst_rd_data",    64'(bus.rd_data),    64'(0));
    check("rst_pc_out",     64'(bus.pc_out),     64'(0));
    check("rst_ccr_out",    64'(bus.ccr_out),    64'(0));
    check("rst_stack_addr", 64'(bus.stack_addr), 64'(12'hFFF));

    // PUSH then POP.
    issue(3'd0, 1'b0, 16'hBEEF, 12'h0, 32'h0, 3'b0);
    issue(3'd1, 1'b0, 16'h0,    12'h0, 32'h0, 3'b0);

    // CALL then RET.
    issue(3'd2, 1'b0, 16'h0, 12'h0, 32'h0001_2345, 3'b0);
    issue(3'd3, 1'b0, 16'h0, 12'h0, 32'h0, 3'b0);

    // int_req beats a simultaneous PUSH; then RTI.
    issue(3'd0, 1'b1, 16'h1111, 12'h0, 32'hDEAD_BEEF, 3'b101);
    issue(3'd5, 1'b0, 16'h0,    12'h0, 32'h0, 3'b0);

    // STD / LDD at ea.
    issue(3'd7, 1'b0, 16'h1234, 12'h010, 32'h0, 3'b0);
    issue(3'd6, 1'b0, 16'h0,    12'h010, 32'h0, 3'b0);
    check("ea_q", 64'(bus.ea_q), 64'(12'h010));

    // Reset in I1: PUSH held on cmd_valid while busy; operands changed after acceptance.
    m_wr(1'b0, 2'b10, sp_m, 16'hCAFE);
    m_wr(1'b0, 2'b01, sp_m - 12'd1, 16'hF00D);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'd4;
    bus.pc        = 32'hCAFE_F00D;
    bus.ccr       = 3'b011;
    @(posedge clk);
    #1;
    bus.cmd = 3'd0;
    bus.pc  = 32'h1111_2222;
    check("i0_busy", 64'(bus.busy), 64'(1));
    @(posedge clk);
    #1;
    check("i1_busy", 64'(bus.busy), 64'(1));
    rst           = 1'b1;
    bus.cmd_valid = 1'b0;
    @(posedge clk);
    #1;
    rst  = 1'b0;
    sp_m = 12'hFFF;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_sp",   64'(bus.stack_addr), 64'(12'hFFF));
    repeat (2) @(posedge clk);
    #1;
    check("abort_idle", 64'(bus.busy), 64'(0));

    // CALL with PUSH held: PUSH is taken in the first IDLE cycle.
    apply_model(3'd2, 16'h0, 12'h0, 32'h0102_0304, 3'b0, dummy);
    apply_model(3'd0, 16'h5A5A, 12'h0, 32'h0102_0304, 3'b0, dummy);
    @(negedge clk);
    bus.cmd_valid = 1'b1;
    bus.cmd       = 3'd2;
    bus.pc        = 32'h0102_0304;
    @(posedge clk);
    #1;
    bus.cmd     = 3'd0;
    bus.alu_out = 16'h5A5A;
    check("held_c0", 64'(bus.busy), 64'(1));
    @(posedge clk);
    #1;
    check("held_c1", 64'(bus.busy), 64'(1));
    @(posedge clk);
    #1;
    check("held_idle", 64'(bus.busy), 64'(0));
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
    check("held_pu", 64'(bus.busy), 64'(1));
    @(posedge clk);
    #1;
    check("held_done", 64'(bus.busy), 64'(0));
    check("held_sp",   64'(bus.stack_addr), 64'(sp_m));

    // Wrap-around: 4096 pushes from reset, then a POP at 000.
    do_reset();
    for (int k = 0; k < 4096; k++) begin
      issue(3'd0, 1'b0, 16'(k) ^ 16'hA5A5, 12'h0, 32'h0, 3'b0);
    end
    check("wrap_sp", 64'(bus.stack_addr), 64'(12'hFFF));
    issue(3'd1, 1'b0, 16'h0, 12'h0, 32'h0, 3'b0);

    repeat (2) @(posedge clk);
    check("sb_drain", 64'(exp_wr.size() + exp_rd.size() + exp_rdv.size() + exp_pc.size() +
                          exp_ccr.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stack_mem_sequencer.md
# stack_mem_sequencer

Multi-cycle sequencer sitting directly upstream of the data-memory stage of the RISC pipeline. It accepts one memory-class command per transaction (PUSH, POP, CALL, RET, INT, RTI, LDD, STD), latches its operands, owns the stack pointer, and drives the data memory's read/write strobes, 4:1 data select, address select and stack address cycle by cycle. Multi-word stack frames for calls and interrupts become sequences of 16-bit accesses. Values read back (popped word, return PC, restored CCR) are presented to the writeback/fetch side.

## Interface
Parameters:
- AW, 12: address width; SP width.
- SP_RESET, 12'hFFF: stack pointer reset value, which is the top of the stack.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered this cycle.
- cmd  in  3  command code: 0 PUSH, 1 POP, 2 CALL, 3 RET, 4 INT, 5 RTI, 6 LDD, 7 STD.
- alu_out  in  16  write data for PUSH/STD.
- ea  in  AW  effective address for LDD/STD.
- pc  in  32  PC to save for CALL/INT.
- ccr  in  3  flags to save for INT.
- int_req  in  1  interrupt request; equivalent to cmd=INT.
- mem_rdata  in  16  data-memory read data.
- busy  out  1  sequencer not in IDLE; commands are ignored while high.
- mem_rd  out  1  data-memory read strobe (MR).
- mem_wr  out  1  data-memory write strobe (MW).
- data_sel  out  2  data select: 00 ALU, 01 PC low, 10 PC high, 11 CCR.
- addr_sel  out  1  address select: 0 = stack address, 1 = ea.
- stack_addr  out  AW  stack address driven to memory.
- ea_q  out  AW  latched effective address.
- rd_valid  out  1  pulses with rd_data for POP/LDD.
- rd_data  out  16  popped or loaded word.
- pc_valid  out  1  pulses with the restored PC for RET/RTI.
- pc_out  out  32  restored PC.
- ccr_valid  out  1  pulses with the restored CCR for RTI.
- ccr_out  out  3  restored flags.

## Operation
- In IDLE, a request is accepted when int_req or cmd_valid is high. int_req has priority over cmd_valid in the same cycle.
- On acceptance, alu_out, ea, pc and ccr are latched. The first memory access happens in the next cycle.
- Stack grows downward. Every push writes at SP, then decrements SP. Every pop increments SP first, then reads at the new SP.
- SP arithmetic is modulo 2^AW: FFF+1 wraps to 000, and 000-1 wraps to FFF. There is no overflow flag.
- Reads: mem_rdata is valid in the cycle after mem_rd.
- Command sequences (states listed in order, then return to IDLE):
  - PUSH: PU (write ALU).
  - POP: PO (read), PD (rd_valid=1, rd_data=mem_rdata).
  - STD: ST (write ALU at ea, addr_sel=1).
  - LDD: LD (read at ea), LDW (rd_valid).
  - CALL: C0 (write PC[31:16]), C1 (write PC[15:0]).
  - INT: I0 (write PC high), I1 (write PC low), I2 (write {13'b0,CCR}).
  - RET: R0 (read PC low), R1 (read PC high; latch PC low), R2 (pc_valid=1, pc_out={mem_rdata, pcl_q}).
  - RTI: T0 (read CCR), T1 (read PC low; latch ccr_out from mem_rdata[2:0]), T2 (read PC high; latch PC low), T3 (pc_valid=1 and ccr_valid=1).
- stack_addr equals the SP value used for that access: current SP for a push, SP+1 for a pop.
- In states with no memory operation, mem_rd, mem_wr and addr_sel are 0.
- addr_sel is 1 only in LD and ST.

## Timing
- Reset values: state IDLE, SP=SP_RESET. All of the following are 0: busy, mem_rd, mem_wr, data_sel, addr_sel, the valid pulses, rd_data, pc_out and ccr_out. stack_addr=SP_RESET.
- Reset mid-sequence aborts the sequence immediately. Partial frames are left in memory, SP returns to SP_RESET, and no valid pulse is issued.
- Total cycles from acceptance to return to IDLE:
  - PUSH, STD: 2.
  - POP, LDD, CALL: 3.
  - INT, RET: 4.
  - RTI: 5.
- busy is high in every non-IDLE state. A new command can be accepted in the first IDLE cycle.
- Valid pulses are exactly 1 cycle wide, in the final state of the sequence.
- Final SP deltas: PUSH -1, POP +1, CALL -2, INT -3, RET +2, RTI +3, LDD/STD 0.

## Test plan
- Reset, PUSH alu_out=16'hBEEF, then POP:
  - write at FFF with data_sel=00, leaving SP=FFE.
  - POP reads FFF, giving rd_valid with rd_data=BEEF, and SP=FFF.
- CALL pc=32'h0001_2345 then RET:
  - writes 0001@FFF (data_sel=10) and 2345@FFE (01), leaving SP=FFD.
  - RET gives pc_valid with pc_out=0001_2345, and SP=FFF.
- int_req and cmd_valid(PUSH) in the same IDLE cycle with ccr=3'b101:
  - INT runs, writing PC high @FFF, PC low @FFE, 0005@FFD, leaving SP=FFC.
  - RTI gives ccr_out=101 and pc_valid in the same cycle.
- Wrap-around:
  - 4096 PUSHes from reset leave SP=FFF. The 4096th push writes at 000.
  - A further POP reads address 000.
- STD ea=12'h010, data=1234, then LDD ea=010:
  - addr_sel=1 on both accesses, SP unchanged.
  - rd_data=1234 in the cycle after the LD read.
- rst asserted in state I1:
  - next cycle: IDLE, busy=0, SP=FFF, no pc_valid/ccr_valid.
  - cmd_valid held during busy is ignored until IDLE.
